// File: rtl/cia_tod_counter.sv
// -----------------------------------------------------------------------------
// cia_tod_counter
//    Time-of-day counter with alarm for a CIA-style peripheral. The counter and
//    the alarm are NBYTES bytes wide and are accessed one byte per register
//    select. Reads go through a hold latch so that a multi-byte read is
//    coherent. A write to the MSB stops counting and a write to the LSB
//    restarts it. When BUGGY_CARRY is set, the carry from the low segment into
//    the upper segment is applied one enabled cycle late, which reproduces the
//    original chip's lost-carry behaviour.
//
// Parameters
//    NBYTES      counter/alarm width in bytes (2..4)
//    SPLIT_BITS  low segment width used by the split-carry mode (1..8*NBYTES-1)
//    BUGGY_CARRY 1: delayed upper-segment carry, 0: single-step increment
//
// Ports
//    i_clk        system clock
//    i_reset_n    asynchronous active-low reset
//    i_clk7_en    clock enable; state changes only when high
//    i_wr         1 = write access, 0 = read access
//    i_sel        one-hot byte select, bit 0 = LSB
//    i_tcr        control register B select (bit 7 = ALARM)
//    i_data_in    bus write data
//    o_data_out   bus read data (combinational)
//    i_count      count tick, one enabled cycle wide
//    o_irq        alarm interrupt request
//    o_running    counting enabled status
// -----------------------------------------------------------------------------
module cia_tod_counter #(
   parameter int NBYTES      = 3,
   parameter int SPLIT_BITS  = 12,
   parameter bit BUGGY_CARRY = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_clk7_en,
   input  logic              i_wr,
   input  logic [NBYTES-1:0] i_sel,
   input  logic              i_tcr,
   input  logic [7:0]        i_data_in,
   output logic [7:0]        o_data_out,
   input  logic              i_count,
   output logic              o_irq,
   output logic              o_running
);

   localparam int W   = 8 * NBYTES;
   localparam int UW  = W - SPLIT_BITS;
   localparam int MSB = NBYTES - 1;

   // Replace every selected byte lane of old_v with data.
   function automatic logic [W-1:0] f_merge_byte(
      input logic [W-1:0]      old_v,
      input logic [NBYTES-1:0] sel,
      input logic [7:0]        data
   );
      logic [W-1:0] v;
      v = old_v;
      for (int i = 0; i < NBYTES; i++) begin
         if (sel[i]) begin
            v[8*i +: 8] = data;
         end
      end
      return v;
   endfunction

   // Return the selected byte lane of v; the lowest selected lane wins.
   function automatic logic [7:0] f_pick_byte(
      input logic [W-1:0]      v,
      input logic [NBYTES-1:0] sel
   );
      logic [7:0] b;
      b = 8'h00;
      for (int i = NBYTES - 1; i >= 0; i--) begin
         if (sel[i]) begin
            b = v[8*i +: 8];
         end
      end
      return b;
   endfunction

   // State
   logic [W-1:0]          r_tod;
   logic [W-1:0]          r_alarm;
   logic [W-1:0]          r_tod_latch;
   logic                  r_crb7;
   logic                  r_count_ena;
   logic                  r_latch_ena;
   logic                  r_count_del;
   logic                  r_count_del2;
   logic                  r_todcarry;

   // Decoded access strobes and next-state values
   logic                  w_tick;
   logic                  w_tod_wr;
   logic                  w_alarm_wr;
   logic                  w_cr_wr;
   logic                  w_wr_lsb;
   logic                  w_wr_msb;
   logic                  w_rd_lsb;
   logic                  w_rd_msb;
   logic [SPLIT_BITS-1:0] w_low;
   logic [UW-1:0]         w_high;
   logic [W-1:0]          w_tod_nxt;
   logic                  w_carry_nxt;
   logic [7:0]            w_data_out;

   // Byte writes land in the alarm instead of the counter while crb7 is set.
   assign w_tod_wr   = i_wr & (|i_sel) & ~r_crb7;
   assign w_alarm_wr = i_wr & (|i_sel) & r_crb7;
   assign w_cr_wr    = i_wr & i_tcr;
   assign w_wr_lsb   = i_wr & i_sel[0] & ~r_crb7;
   assign w_wr_msb   = i_wr & i_sel[MSB] & ~r_crb7;
   assign w_rd_lsb   = ~i_wr & i_sel[0];
   assign w_rd_msb   = ~i_wr & i_sel[MSB] & ~r_crb7;
   assign w_tick     = i_count & r_count_ena;
   assign w_low      = r_tod[SPLIT_BITS-1:0];
   assign w_high     = r_tod[W-1:SPLIT_BITS];

   // Next counter value: a bus write beats a tick, and a tick beats the
   // delayed upper-segment carry (so a back-to-back tick loses that carry).
   always_comb begin
      w_tod_nxt   = r_tod;
      w_carry_nxt = r_todcarry;
      if (w_tod_wr) begin
         w_tod_nxt = f_merge_byte(r_tod, i_sel, i_data_in);
      end else if (w_tick) begin
         if (BUGGY_CARRY) begin
            w_tod_nxt[SPLIT_BITS-1:0] = w_low + SPLIT_BITS'(1'b1);
            w_carry_nxt               = (w_low == {SPLIT_BITS{1'b1}});
         end else begin
            w_tod_nxt = r_tod + W'(1'b1);
         end
      end else if (BUGGY_CARRY && r_count_del) begin
         w_tod_nxt[W-1:SPLIT_BITS] = w_high + UW'(r_todcarry);
      end else begin
         w_tod_nxt = r_tod;
      end
   end

   // Counter and pending low-segment carry.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_tod      <= {W{1'b0}};
         r_todcarry <= 1'b0;
      end else if (i_clk7_en) begin
         r_tod      <= w_tod_nxt;
         r_todcarry <= w_carry_nxt;
      end
   end

   // Alarm register; resets to all ones so it cannot match a freshly reset counter.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_alarm <= {W{1'b1}};
      end else if (i_clk7_en && w_alarm_wr) begin
         r_alarm <= f_merge_byte(r_alarm, i_sel, i_data_in);
      end
   end

   // Control bit 7 and the count enable (MSB write stops, LSB or CR write restarts).
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_crb7      <= 1'b0;
         r_count_ena <= 1'b0;
      end else if (i_clk7_en) begin
         if (w_cr_wr) begin
            r_crb7 <= i_data_in[7];
         end
         if (w_wr_msb) begin
            r_count_ena <= 1'b0;
         end else if (w_wr_lsb || (w_cr_wr && !i_data_in[7])) begin
            r_count_ena <= 1'b1;
         end
      end
   end

   // Read hold latch: an MSB read freezes the snapshot, an LSB read releases it.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_tod_latch <= {W{1'b0}};
         r_latch_ena <= 1'b1;
      end else if (i_clk7_en) begin
         if (r_latch_ena) begin
            r_tod_latch <= r_tod;
         end
         if (w_rd_msb) begin
            r_latch_ena <= 1'b0;
         end else if (w_rd_lsb) begin
            r_latch_ena <= 1'b1;
         end
      end
   end

   // Tick delay line; it drives the delayed carry and qualifies the alarm match.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count_del  <= 1'b0;
         r_count_del2 <= 1'b0;
      end else if (i_clk7_en) begin
         r_count_del  <= i_count & r_count_ena;
         r_count_del2 <= r_count_del & r_count_ena;
      end
   end

   // Read mux: byte selects take priority over the control register.
   always_comb begin
      w_data_out = 8'h00;
      if (!i_wr && (|i_sel)) begin
         w_data_out = f_pick_byte(r_tod_latch, i_sel);
      end else if (!i_wr && i_tcr) begin
         w_data_out = {r_crb7, 7'b000_0000};
      end else begin
         w_data_out = 8'h00;
      end
   end

   assign o_data_out = w_data_out;
   // Only a match following a tick raises irq, so a write-created match stays silent.
   assign o_irq      = (r_tod == r_alarm) & (r_count_del | r_count_del2);
   assign o_running  = r_count_ena;

endmodule

// File: tb/tb_cia_tod_counter.sv
// -----------------------------------------------------------------------------
// tb_cia_tod_counter
//    Two instances: A = 3 bytes with split carry, B = 4 bytes with plain
//    increment. A behavioural model tracks both and is compared against the
//    outputs on every falling clock edge; directed sequences add literal
//    expectations, followed by randomized bus traffic.
// -----------------------------------------------------------------------------
module tb_cia_tod_counter;

   typedef struct packed {
      logic       wr;
      logic [3:0] sel;
      logic       tcr;
      logic [7:0] din;
      logic       count;
   } in_t;

   typedef struct {
      logic [31:0] tod;
      logic [31:0] alarm;
      logic [31:0] latch;
      logic        crb7;
      logic        cena;
      logic        lena;
      logic        cdel;
      logic        cdel2;
      logic        carry;
   } m_t;

   localparam in_t IDLE = '0;

   logic       clk = 1'b0;
   logic       rst_n;
   in_t        a_in;
   in_t        b_in;
   logic       a_en;
   logic       b_en;
   logic [7:0] a_dout;
   logic [7:0] b_dout;
   logic       a_irq;
   logic       b_irq;
   logic       a_run;
   logic       b_run;
   m_t         ma;
   m_t         mb;
   int         n_chk = 0;
   int         n_err = 0;
   bit         chk_on = 1'b0;

   always #5 clk = ~clk;

   cia_tod_counter #(.NBYTES(3), .SPLIT_BITS(12), .BUGGY_CARRY(1'b1)) u_dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_clk7_en(a_en), .i_wr(a_in.wr),
      .i_sel(a_in.sel[2:0]), .i_tcr(a_in.tcr), .i_data_in(a_in.din),
      .o_data_out(a_dout), .i_count(a_in.count), .o_irq(a_irq), .o_running(a_run)
   );

   cia_tod_counter #(.NBYTES(4), .SPLIT_BITS(12), .BUGGY_CARRY(1'b0)) u_dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_clk7_en(b_en), .i_wr(b_in.wr),
      .i_sel(b_in.sel), .i_tcr(b_in.tcr), .i_data_in(b_in.din),
      .o_data_out(b_dout), .i_count(b_in.count), .o_irq(b_irq), .o_running(b_run)
   );

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] wmask(int nb);
      return (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
   endfunction

   function automatic m_t m_reset(int nb);
      m_t s;
      s.tod = 32'h0; s.alarm = wmask(nb); s.latch = 32'h0;
      s.crb7 = 1'b0; s.cena = 1'b0; s.lena = 1'b1;
      s.cdel = 1'b0; s.cdel2 = 1'b0; s.carry = 1'b0;
      return s;
   endfunction

   // One enabled cycle; the split point for the buggy mode is 12 bits.
   function automatic m_t m_step(m_t s, in_t x, int nb, bit buggy);
      m_t          n;
      logic        tick;
      logic [31:0] low;
      n = s;
      tick = x.count && s.cena;
      if (x.wr && x.sel != 4'h0 && !s.crb7) begin
         for (int b = 0; b < nb; b++) if (x.sel[b]) n.tod[8*b +: 8] = x.din;
      end else if (tick) begin
         if (buggy) begin
            low = s.tod % 32'd4096;
            n.carry = (low == 32'd4095);
            n.tod = s.tod - low + ((low + 32'd1) % 32'd4096);
         end else begin
            n.tod = (s.tod + 32'd1) & wmask(nb);
         end
      end else if (buggy && s.cdel) begin
         n.tod = (s.tod + (s.carry ? 32'd4096 : 32'd0)) & wmask(nb);
      end
      if (x.wr && x.sel != 4'h0 && s.crb7) begin
         for (int b = 0; b < nb; b++) if (x.sel[b]) n.alarm[8*b +: 8] = x.din;
      end
      if (x.wr && x.tcr) n.crb7 = x.din[7];
      if (x.wr && x.sel[nb-1] && !s.crb7) n.cena = 1'b0;
      else if ((x.wr && x.sel[0] && !s.crb7) || (x.wr && x.tcr && !x.din[7])) n.cena = 1'b1;
      n.cdel = tick;
      n.cdel2 = s.cdel && s.cena;
      if (s.lena) n.latch = s.tod;
      if (!x.wr && x.sel[nb-1] && !s.crb7) n.lena = 1'b0;
      else if (!x.wr && x.sel[0]) n.lena = 1'b1;
      return n;
   endfunction

   function automatic logic [7:0] m_dout(m_t s, in_t x, int nb);
      if (!x.wr) begin
         for (int b = 0; b < nb; b++) if (x.sel[b]) return s.latch[8*b +: 8];
         if (x.tcr) return {s.crb7, 7'b0};
      end
      return 8'h00;
   endfunction

   function automatic logic m_irq(m_t s);
      return (s.tod == s.alarm) && (s.cdel || s.cdel2);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma = m_reset(3);
         mb = m_reset(4);
      end else begin
         if (a_en) ma = m_step(ma, a_in, 3, 1'b1);
         if (b_en) mb = m_step(mb, b_in, 4, 1'b0);
      end
   end

   // ---------------- checking ----------------
   task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(string nm, logic act, logic exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk8("a_data_out", a_dout, m_dout(ma, a_in, 3));
         chk1("a_irq", a_irq, m_irq(ma));
         chk1("a_running", a_run, ma.cena);
         chk8("b_data_out", b_dout, m_dout(mb, b_in, 4));
         chk1("b_irq", b_irq, m_irq(mb));
         chk1("b_running", b_run, mb.cena);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_in(int d, in_t x);
      if (d == 0) a_in = x; else b_in = x;
   endtask

   task automatic cyc(int d, in_t x);
      set_in(d, x);
      @(posedge clk); #1;
      set_in(d, IDLE);
   endtask

   task automatic wrb(int d, int b, logic [7:0] val, logic tick);
      in_t x;
      x = IDLE; x.wr = 1'b1; x.sel = 4'(1 << b); x.din = val; x.count = tick;
      cyc(d, x);
   endtask

   task automatic wcr(int d, logic [7:0] val);
      in_t x;
      x = IDLE; x.wr = 1'b1; x.tcr = 1'b1; x.din = val;
      cyc(d, x);
   endtask

   task automatic tk(int d);
      in_t x;
      x = IDLE; x.count = 1'b1;
      cyc(d, x);
   endtask

   task automatic idle(int d, int n);
      repeat (n) cyc(d, IDLE);
   endtask

   task automatic rdb(int d, int b, output logic [7:0] v);
      in_t x;
      x = IDLE; x.sel = 4'(1 << b);
      set_in(d, x);
      @(negedge clk);
      v = (d == 0) ? a_dout : b_dout;
      @(posedge clk); #1;
      set_in(d, IDLE);
   endtask

   task automatic peek(int d, output logic irq, output logic run);
      @(negedge clk);
      irq = (d == 0) ? a_irq : b_irq;
      run = (d == 0) ? a_run : b_run;
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] pick_data();
      case ($urandom_range(0, 3))
         0:       return 8'hFF;
         1:       return 8'h0F;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   function automatic in_t rnd(int nb);
      in_t x;
      int  r;
      x = IDLE;
      r = $urandom_range(0, 99);
      x.count = ($urandom_range(0, 1) == 1);
      if (r < 12) begin
         x.sel = 4'(1 << $urandom_range(0, nb - 1));
      end else if (r < 15) begin
         x.tcr = 1'b1;
      end else if (r < 22) begin
         x.wr = 1'b1; x.sel = 4'(1 << $urandom_range(0, nb - 1)); x.din = pick_data();
      end else if (r < 25) begin
         x.wr = 1'b1; x.tcr = 1'b1; x.din = 8'($urandom_range(0, 255));
      end
      return x;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [7:0] v;
      logic       irq;
      logic       run;
      int         hi_cnt;
      a_in = IDLE; b_in = IDLE; a_en = 1'b1; b_en = 1'b1;
      rst_n = 1'b0;
      ma = m_reset(3); mb = m_reset(4);
      chk_on = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // T1: no counting before the first LSB/CR write
      tk(0);
      peek(0, irq, run);
      chk1("t1_running_off", run, 1'b0);
      chk1("t1_irq_off", irq, 1'b0);
      rdb(0, 0, v);  chk8("t1_tod_zero", v, 8'h00);
      wrb(0, 0, 8'h00, 1'b0);
      peek(0, irq, run);
      chk1("t1_running_on", run, 1'b1);

      // T2: read latch
      wrb(0, 2, 8'h00, 1'b0); wrb(0, 1, 8'h00, 1'b0); wrb(0, 0, 8'hFF, 1'b0);
      rdb(0, 2, v);  chk8("t2_msb", v, 8'h00);
      tk(0); tk(0); tk(0);
      rdb(0, 1, v);  chk8("t2_mid_frozen", v, 8'h00);
      rdb(0, 0, v);  chk8("t2_lsb_frozen", v, 8'hFF);
      idle(0, 1);
      rdb(0, 0, v);  chk8("t2_lsb_live", v, 8'h02);

      // T3: split carry appears one enabled cycle late
      wrb(0, 2, 8'h00, 1'b0); wrb(0, 1, 8'h0F, 1'b0); wrb(0, 0, 8'hFF, 1'b0);
      tk(0);
      idle(0, 1);
      rdb(0, 1, v);  chk8("t3_mid_transient", v, 8'h00);
      rdb(0, 1, v);  chk8("t3_mid_carried", v, 8'h10);

      // T3: back-to-back ticks lose the carry
      wrb(0, 2, 8'h00, 1'b0); wrb(0, 1, 8'h0F, 1'b0); wrb(0, 0, 8'hFF, 1'b0);
      tk(0); tk(0);
      idle(0, 2);
      rdb(0, 1, v);  chk8("t3_lost_mid", v, 8'h00);
      rdb(0, 0, v);  chk8("t3_lost_lsb", v, 8'h01);

      // T4: alarm 0x000010, tod 0x00000F, one tick
      wcr(0, 8'h80);
      wrb(0, 2, 8'h00, 1'b0); wrb(0, 1, 8'h00, 1'b0); wrb(0, 0, 8'h10, 1'b0);
      wcr(0, 8'h00);
      wrb(0, 2, 8'h00, 1'b0); wrb(0, 1, 8'h00, 1'b0); wrb(0, 0, 8'h0F, 1'b0);
      tk(0);
      hi_cnt = 0;
      peek(0, irq, run);  chk1("t4_irq_first", irq, 1'b1);
      if (irq) hi_cnt++;
      for (int i = 0; i < 3; i++) begin
         peek(0, irq, run);
         if (irq) hi_cnt++;
      end
      chk1("t4_irq_width", (hi_cnt >= 1) && (hi_cnt <= 2), 1'b1);
      chk1("t4_irq_gone", irq, 1'b0);

      // T4: a match made by a write alone gives no irq
      wrb(0, 0, 8'h05, 1'b0);
      wrb(0, 0, 8'h10, 1'b0);
      peek(0, irq, run);  chk1("t4_nofalse_0", irq, 1'b0);
      peek(0, irq, run);  chk1("t4_nofalse_1", irq, 1'b0);

      // T5: MSB write stops, LSB write resumes
      wrb(0, 2, 8'h12, 1'b0);
      tk(0); tk(0); tk(0);
      idle(0, 1);
      rdb(0, 0, v);  chk8("t5_stopped", v, 8'h10);
      wrb(0, 0, 8'h34, 1'b0);
      tk(0);
      idle(0, 1);
      rdb(0, 0, v);  chk8("t5_resumed_lsb", v, 8'h35);
      rdb(0, 1, v);  chk8("t5_resumed_mid", v, 8'h00);
      rdb(0, 2, v);  chk8("t5_resumed_msb", v, 8'h12);
      rdb(0, 0, v);  chk8("t5_relatch", v, 8'h35);

      // T5: tick in the same cycle as a tod write is dropped
      wrb(0, 2, 8'h00, 1'b0); wrb(0, 1, 8'h00, 1'b0); wrb(0, 0, 8'h3F, 1'b0);
      wrb(0, 0, 8'h40, 1'b1);
      idle(0, 2);
      rdb(0, 0, v);  chk8("t5_write_wins", v, 8'h40);

      // T6: 4-byte plain counter wraps, alarm 0 fires
      wrb(1, 3, 8'hFF, 1'b0); wrb(1, 2, 8'hFF, 1'b0);
      wrb(1, 1, 8'hFF, 1'b0); wrb(1, 0, 8'hFF, 1'b0);
      wcr(1, 8'h80);
      wrb(1, 3, 8'h00, 1'b0); wrb(1, 2, 8'h00, 1'b0);
      wrb(1, 1, 8'h00, 1'b0); wrb(1, 0, 8'h00, 1'b0);
      wcr(1, 8'h00);
      idle(1, 1);
      rdb(1, 1, v);  chk8("t6_before_wrap", v, 8'hFF);
      tk(1);
      peek(1, irq, run);  chk1("t6_irq", irq, 1'b1);
      idle(1, 1);
      rdb(1, 3, v);  chk8("t6_wrap_msb", v, 8'h00);
      rdb(1, 0, v);  chk8("t6_wrap_lsb", v, 8'h00);

      // Reset in the middle of a pending carry
      wrb(0, 2, 8'h00, 1'b0); wrb(0, 1, 8'h0F, 1'b0); wrb(0, 0, 8'hFF, 1'b0);
      tk(0);
      #2 rst_n = 1'b0;
      #1;
      chk1("rst_mid_running", a_run, 1'b0);
      chk1("rst_mid_irq", a_irq, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      idle(0, 2);
      rdb(0, 1, v);  chk8("rst_carry_cleared", v, 8'h00);
      peek(0, irq, run);  chk1("rst_running_off", run, 1'b0);

      // Randomized traffic with random clock enables
      for (int i = 0; i < 3000; i++) begin
         a_en = ($urandom_range(0, 3) != 0);
         b_en = ($urandom_range(0, 3) != 0);
         a_in = rnd(3);
         b_in = rnd(4);
         @(posedge clk); #1;
      end
      a_in = IDLE; b_in = IDLE; a_en = 1'b1; b_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
